// File: rtl/pixel_sink_pkg.sv
// Shared constants, plot-queue entry type and FSM states for the pixel sink.
// Framebuffer address of a pixel is y*SCR_WIDTH + x (see pixAddr).
package pixel_sink_pkg;

    localparam int SCR_WIDTH       = 160;
    localparam int SCR_HEIGHT      = 120;
    localparam int SCR_WIDTH_BITS  = 8;
    localparam int SCR_HEIGHT_BITS = 7;
    localparam int COLOR_SIZE      = 3;

    localparam int X_BITS          = SCR_WIDTH_BITS;
    localparam int Y_BITS          = SCR_HEIGHT_BITS;
    localparam int COLOR_BITS      = COLOR_SIZE;
    localparam int ADDR_BITS       = 15;
    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_CNT_BITS   = $clog2(FIFO_DEPTH) + 1;
    localparam int SCREEN_PIXELS   = SCR_WIDTH * SCR_HEIGHT;

    typedef enum logic [1:0] {
        S_STREAM = 2'd0,
        S_CLEAR  = 2'd1,
        S_DONE   = 2'd2
    } sink_state_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] color;
    } plot_entry_t;

    function automatic logic [ADDR_BITS-1:0] pixAddr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return ADDR_BITS'(y) * ADDR_BITS'(SCR_WIDTH) + ADDR_BITS'(x);
    endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// Framebuffer write port: a write transfers on a cycle where mem_we && mem_ready.
// The sink is the master; the video memory is the slave.
interface pixel_sink_if;
    import pixel_sink_pkg::*;

    logic [ADDR_BITS-1:0]  mem_addr;
    logic [COLOR_BITS-1:0] mem_data;
    logic                  mem_we;
    logic                  mem_ready;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_ready
    );

endinterface

// File: rtl/pixel_sink_fifo.sv
// Small synchronous FIFO for queued plots; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module pixel_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0]   CNT_ONE = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]   CNT_MAX = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wrPtr_q;
    logic [PTR_BITS-1:0] rdPtr_q;
    logic [PTR_BITS:0]   count_q;
    logic                doPush;
    logic                doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Storage is cleared on reset so the head (and thus the write port) reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata_i;
                wrPtr_q        <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Turns painter plot strobes into framebuffer writes and provides a whole-screen clear sweep.
// Define PIXEL_SINK_STATS_EN to add the written_count / drop_count statistics ports.
module pixel_sink
    import pixel_sink_pkg::*;
(
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic [X_BITS-1:0]     paint_x_co,
    input  logic [Y_BITS-1:0]     paint_y_co,
    input  logic [COLOR_BITS-1:0] color,
    input  logic                  print_enable,
    input  logic                  clear_req,
    input  logic [COLOR_BITS-1:0] clear_color,
    pixel_sink_if.master          memIf,
    output logic                  clear_done,
    output logic                  busy,
    output logic                  overflow
`ifdef PIXEL_SINK_STATS_EN
    ,
    output logic [15:0]           written_count,
    output logic [7:0]            drop_count
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCREEN_PIXELS - 1);

    sink_state_e             state_q;
    logic [ADDR_BITS-1:0]    sweepAddr_q;
    logic [COLOR_BITS-1:0]   clearColor_q;
    logic                    clearPending_q;
    logic                    prevEnable_q;
    logic                    overflow_q;

    logic                    plotEvent;
    logic                    inRange;
    logic                    fifoPush;
    logic                    fifoPop;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [FIFO_CNT_BITS-1:0] fifoCount;
    logic                    plotLost;
    plot_entry_t             newEntry;
    plot_entry_t             headEntry;

    assign plotEvent = print_enable && !prevEnable_q;
    assign inRange   = (paint_x_co < X_BITS'(SCR_WIDTH)) && (paint_y_co < Y_BITS'(SCR_HEIGHT));

    assign newEntry.addr  = pixAddr(paint_x_co, paint_y_co);
    assign newEntry.color = color;

    // Only streaming mode drains the queue; plots arriving during a sweep wait in it.
    assign fifoPop  = (state_q == S_STREAM) && !fifoEmpty && memIf.mem_ready;
    assign fifoPush = plotEvent && inRange && (!fifoFull || fifoPop);
    assign plotLost = plotEvent && inRange && !fifoPush;

    pixel_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(plot_entry_t))
    ) u_fifo (
        .clk     (Clck),
        .rst_n   (Reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (newEntry),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign memIf.mem_we   = (state_q == S_CLEAR) || ((state_q == S_STREAM) && !fifoEmpty);
    assign memIf.mem_addr = (state_q == S_CLEAR) ? sweepAddr_q  : headEntry.addr;
    assign memIf.mem_data = (state_q == S_CLEAR) ? clearColor_q : headEntry.color;

    assign clear_done = (state_q == S_DONE);
    assign busy       = (fifoCount != '0) || clearPending_q || (state_q != S_STREAM);
    assign overflow   = overflow_q;

    // A pending clear waits for the queue to empty so earlier plots land before the sweep.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q        <= S_STREAM;
            sweepAddr_q    <= '0;
            clearColor_q   <= '0;
            clearPending_q <= 1'b0;
        end else begin
            case (state_q)
                S_STREAM: begin
                    if (clearPending_q && fifoEmpty) begin
                        state_q        <= S_CLEAR;
                        sweepAddr_q    <= '0;
                        clearColor_q   <= clear_color;
                        clearPending_q <= 1'b0;
                    end else if (clear_req) begin
                        clearPending_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (memIf.mem_ready) begin
                        if (sweepAddr_q == LAST_ADDR) begin
                            state_q <= S_DONE;
                        end else begin
                            sweepAddr_q <= sweepAddr_q + ADDR_BITS'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_STREAM;
                end
                default: begin
                    state_q <= S_STREAM;
                end
            endcase
        end
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            prevEnable_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            prevEnable_q <= print_enable;
            if (plotLost) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] writtenCount_q;
    logic [7:0]  dropCount_q;

    // Sweep writes are deliberately excluded; only queued plots count as written.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            writtenCount_q <= '0;
            dropCount_q    <= '0;
        end else begin
            if (fifoPop && (writtenCount_q != 16'hFFFF)) begin
                writtenCount_q <= writtenCount_q + 16'd1;
            end
            if (plotEvent && (!inRange || plotLost) && (dropCount_q != 8'hFF)) begin
                dropCount_q <= dropCount_q + 8'd1;
            end
        end
    end

    assign written_count = writtenCount_q;
    assign drop_count    = dropCount_q;
`endif

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: plot capture, range rejection, overflow, clear sweep, reset mid-sweep.
module tb_pixel_sink;
    import pixel_sink_pkg::*;

    logic                  Clck;
    logic                  Reset;
    logic [X_BITS-1:0]     paint_x_co;
    logic [Y_BITS-1:0]     paint_y_co;
    logic [COLOR_BITS-1:0] color;
    logic                  print_enable;
    logic                  clear_req;
    logic [COLOR_BITS-1:0] clear_color;
    logic                  clear_done;
    logic                  busy;
    logic                  overflow;
`ifdef PIXEL_SINK_STATS_EN
    logic [15:0]           written_count;
    logic [7:0]            drop_count;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int clearDonePulses = 0;
    plot_entry_t wrLog[$];

    pixel_sink_if memIf();

    pixel_sink dut (
        .Clck         (Clck),
        .Reset        (Reset),
        .paint_x_co   (paint_x_co),
        .paint_y_co   (paint_y_co),
        .color        (color),
        .print_enable (print_enable),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .memIf        (memIf),
        .clear_done   (clear_done),
        .busy         (busy),
        .overflow     (overflow)
`ifdef PIXEL_SINK_STATS_EN
        ,
        .written_count(written_count),
        .drop_count   (drop_count)
`endif
    );

    initial Clck = 1'b0;
    always #5 Clck = ~Clck;

    // Passive write/pulse logger sampled on the active edge.
    always @(posedge Clck) begin
        if (memIf.mem_we && memIf.mem_ready) begin
            wrLog.push_back('{addr: memIf.mem_addr, color: memIf.mem_data});
        end
        if (clear_done) begin
            clearDonePulses++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input int c);
        @(negedge Clck);
        paint_x_co   = X_BITS'(x);
        paint_y_co   = Y_BITS'(y);
        color        = COLOR_BITS'(c);
        print_enable = 1'b1;
        @(negedge Clck);
        print_enable = 1'b0;
    endtask

    initial begin
        int k;
        int bad;
        int logBase;
        Reset           = 1'b0;
        paint_x_co      = '0;
        paint_y_co      = '0;
        color           = '0;
        print_enable    = 1'b0;
        clear_req       = 1'b0;
        clear_color     = '0;
        memIf.mem_ready = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_we", memIf.mem_we, 0);
        checkOutput("rst_addr", memIf.mem_addr, 0);
        checkOutput("rst_data", memIf.mem_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_done", clear_done, 0);
        repeat (2) @(negedge Clck);
        Reset = 1'b1;
        memIf.mem_ready = 1'b1;

        // Single plot held three cycles: one write at 2*160+3 = 323
        @(negedge Clck);
        paint_x_co = 8'd3; paint_y_co = 7'd2; color = 3'b010; print_enable = 1'b1;
        @(negedge Clck);
        checkOutput("t1_we_n1", memIf.mem_we, 1);
        checkOutput("t1_addr", memIf.mem_addr, 323);
        checkOutput("t1_data", memIf.mem_data, 3'b010);
        @(negedge Clck);
        checkOutput("t1_we_n2", memIf.mem_we, 0);
        @(negedge Clck);
        print_enable = 1'b0;
        @(negedge Clck);
        checkOutput("t1_nwrites", wrLog.size(), 1);
        if (wrLog.size() >= 1) begin
            checkOutput("t1_log", wrLog[0], {15'd323, 3'b010});
        end

        // Out-of-range plots are dropped without touching overflow
        applyStimulus(160, 5, 1);
        applyStimulus(5, 120, 2);
        repeat (2) @(negedge Clck);
        checkOutput("t2_nwrites", wrLog.size(), 1);
        checkOutput("t2_ovf", overflow, 0);
        checkOutput("t2_busy", busy, 0);
`ifdef PIXEL_SINK_STATS_EN
        checkOutput("t2_drops", drop_count, 2);
`endif

        // Six plots with the memory stalled: four queue, two are lost
        memIf.mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(10 + i, 0, i + 1);
        end
        @(negedge Clck);
        checkOutput("t3_ovf", overflow, 1);
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_we_stall", memIf.mem_we, 1);
        checkOutput("t3_addr_stall", memIf.mem_addr, 10);
        checkOutput("t3_data_stall", memIf.mem_data, 1);
        memIf.mem_ready = 1'b1;
        repeat (3) @(negedge Clck);
        checkOutput("t3_busy_mid", busy, 1);
        @(negedge Clck);
        checkOutput("t3_busy_end", busy, 0);
        checkOutput("t3_nwrites", wrLog.size(), 5);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i + 1 >= wrLog.size() || wrLog[i + 1] !== {15'(10 + i), 3'(i + 1)}) bad++;
        end
        checkOutput("t3_order", bad, 0);
`ifdef PIXEL_SINK_STATS_EN
        checkOutput("t3_drops", drop_count, 4);
        checkOutput("t3_written", written_count, 5);
`endif

        // Clear with two plots queued, plus one plot arriving mid-sweep
        memIf.mem_ready = 1'b0;
        logBase = wrLog.size();
        applyStimulus(1, 1, 7);
        applyStimulus(2, 1, 5);
        @(negedge Clck);
        clear_color = 3'b110;
        clear_req   = 1'b1;
        @(negedge Clck);
        clear_req   = 1'b0;
        checkOutput("t4_busy_pend", busy, 1);
        memIf.mem_ready = 1'b1;
        k = 0;
        while (k < 20000 && !clear_done) begin
            @(negedge Clck);
            k++;
            if (k == 100) begin
                paint_x_co = 8'd7; paint_y_co = 7'd3; color = 3'b001; print_enable = 1'b1;
            end else if (k == 101) begin
                print_enable = 1'b0;
            end
        end
        checkOutput("t4_done_seen", clear_done, 1);
        checkOutput("t4_done_cycle", k, 19203);
        checkOutput("t4_we_done", memIf.mem_we, 0);
        @(negedge Clck);
        checkOutput("t4_done_pulse", clear_done, 0);
        checkOutput("t5_we_after", memIf.mem_we, 1);
        checkOutput("t5_addr_after", memIf.mem_addr, 487);
        @(negedge Clck);
        checkOutput("t4_busy_end", busy, 0);
        checkOutput("t4_nwrites", wrLog.size() - logBase, 19203);
        if (wrLog.size() >= logBase + 2) begin
            checkOutput("t4_plot_a", wrLog[logBase], {15'd161, 3'b111});
            checkOutput("t4_plot_b", wrLog[logBase + 1], {15'd162, 3'b101});
        end
        bad = 0;
        for (int i = 0; i < SCREEN_PIXELS; i++) begin
            if (logBase + 2 + i >= wrLog.size() || wrLog[logBase + 2 + i] !== {15'(i), 3'b110}) bad++;
        end
        checkOutput("t4_sweep", bad, 0);
        if (wrLog.size() >= 1) begin
            checkOutput("t5_plot_last", wrLog[wrLog.size() - 1], {15'd487, 3'b001});
        end
        checkOutput("t4_pulses", clearDonePulses, 1);

        // Reset in the middle of a sweep
        clear_color = 3'b011;
        @(negedge Clck);
        clear_req = 1'b1;
        @(negedge Clck);
        clear_req = 1'b0;
        k = 0;
        while (k < 6000 && !(memIf.mem_we && memIf.mem_addr == 15'd5000)) begin
            @(negedge Clck);
            k++;
        end
        checkOutput("t6_reach_5000", memIf.mem_addr, 5000);
        Reset = 1'b0;
        #1;
        checkOutput("t6_we_rst", memIf.mem_we, 0);
        checkOutput("t6_state", dut.state_q, S_STREAM);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_ovf", overflow, 0);
        logBase = wrLog.size();
        repeat (2) @(negedge Clck);
        Reset = 1'b1;
        repeat (10) @(negedge Clck);
        checkOutput("t6_no_writes", wrLog.size() - logBase, 0);
        checkOutput("t6_no_done", clearDonePulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
